// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF stage. Owns the PC and drives the instruction-memory
// address. Holds the IF/ID latch and resolves branch, jump and jump-register
// redirects with MIPS delay-slot handling. A redirect that cannot be taken
// because the current fetch is stalled or waiting on memory is parked as a
// pending target. That target is applied once the in-flight word (the delay
// slot) completes.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        takeBranch,
    input  logic [31:0] braPc,
    input  logic [15:0] braImm,
    input  logic        jumpEnable,
    input  logic [25:0] jumpTarget,
    input  logic        jrEnable,
    input  logic [31:0] jrTarget,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    output logic        instrValid,
    output logic        redirectPending
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_PEND  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic [31:0] r_pc;
    logic [31:0] r_pendTarget;
    logic [31:0] r_instr;
    logic [31:0] r_instrPc;
    logic        r_instrValid;

    logic [31:0] w_braPcPlus4;
    logic [31:0] w_brOffset;
    logic [31:0] w_brTgt;
    logic [31:0] w_jTgt;
    logic [31:0] w_tgt;
    logic        w_redirect;
    logic        w_fire;
    logic [31:0] w_pcPlus4;

    assign w_braPcPlus4 = braPc + 32'd4;
    assign w_brOffset   = {{14{braImm[15]}}, braImm, 2'b00};
    assign w_brTgt      = w_braPcPlus4 + w_brOffset;
    assign w_jTgt       = {w_braPcPlus4[31:28], jumpTarget, 2'b00};
    assign w_pcPlus4    = r_pc + 32'd4;
    assign w_redirect   = jrEnable | jumpEnable | takeBranch;
    assign w_fire       = imemReady & ~stall;

    // Target selection: JR beats J, and J beats a taken branch.
    always_comb begin
        w_tgt = w_brTgt;
        if (jrEnable) begin
            w_tgt = jrTarget;
        end else if (jumpEnable) begin
            w_tgt = w_jTgt;
        end
    end

    // Next-state logic: park a redirect that cannot fire, release it on fire.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_FETCH: begin
                if (!w_fire && w_redirect) begin
                    w_stateNext = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_fire) begin
                    w_stateNext = ST_FETCH;
                end
            end
            default: w_stateNext = ST_FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // PC, pending target and IF/ID latch updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_pendTarget <= '0;
            r_instr      <= '0;
            r_instrPc    <= '0;
            r_instrValid <= 1'b0;
        end else if (w_fire) begin
            r_instr   <= imemData;
            r_instrPc <= r_pc;
            if (r_state == ST_PEND) begin
                // The completing word is the delay slot of the parked redirect.
                r_instrValid <= DELAY_SLOT;
                r_pc         <= r_pendTarget;
            end else begin
                r_instrValid <= !(w_redirect && !DELAY_SLOT);
                r_pc         <= w_redirect ? w_tgt : w_pcPlus4;
            end
        end else begin
            if (!stall) begin
                r_instrValid <= 1'b0;
            end
            // ID keeps re-asserting a stalled branch, so the latest target wins.
            if (w_redirect) begin
                r_pendTarget <= w_tgt;
            end
        end
    end

    assign imemAddr        = r_pc;
    assign instr           = r_instr;
    assign instrPc         = r_instrPc;
    assign instrValid      = r_instrValid;
    assign redirectPending = (r_state == ST_PEND);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic.
// Two instances share all inputs: one keeps the delay slot, one squashes it.
// The expected values come from a behavioural model of fetch and redirect.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, takeBranch, jumpEnable, jrEnable, imemReady;
    logic [31:0] braPc, jrTarget, imemData;
    logic [15:0] braImm;
    logic [25:0] jumpTarget;

    logic [31:0] a1, i1, p1, a0, i0, p0;
    logic        v1, rp1, v0, rp0;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_instrPc, m_pendTgt;
    logic        m_v1, m_v0, m_pend;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .takeBranch(takeBranch),
        .braPc(braPc), .braImm(braImm), .jumpEnable(jumpEnable),
        .jumpTarget(jumpTarget), .jrEnable(jrEnable), .jrTarget(jrTarget),
        .imemAddr(a1), .imemReady(imemReady), .imemData(imemData),
        .instr(i1), .instrPc(p1), .instrValid(v1), .redirectPending(rp1));

    pc_fetch_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .takeBranch(takeBranch),
        .braPc(braPc), .braImm(braImm), .jumpEnable(jumpEnable),
        .jumpTarget(jumpTarget), .jrEnable(jrEnable), .jrTarget(jrTarget),
        .imemAddr(a0), .imemReady(imemReady), .imemData(imemData),
        .instr(i0), .instrPc(p0), .instrValid(v0), .redirectPending(rp0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] target();
        logic [31:0] seq;
        logic [31:0] off;
        seq = braPc + 32'd4;
        off = 32'(signed'(braImm)) * 32'd4;
        if (jrEnable)        return jrTarget;
        else if (jumpEnable) return {seq[31:28], jumpTarget, 2'b00};
        else                 return seq + off;
    endfunction

    // Advance one clock: evaluate the model on the pre-edge inputs, then
    // compare both instances against it shortly after the edge.
    task automatic cycle();
        logic        red;
        logic [31:0] t;
        red = jrEnable | jumpEnable | takeBranch;
        t   = target();
        if (rst) begin
            m_pc = 32'h3000; m_pend = 0; m_pendTgt = 0;
            m_instr = 0; m_instrPc = 0; m_v1 = 0; m_v0 = 0;
        end else if (imemReady && !stall) begin
            m_instr = imemData;
            m_instrPc = m_pc;
            if (m_pend) begin
                m_v1 = 1; m_v0 = 0; m_pc = m_pendTgt; m_pend = 0;
            end else begin
                m_v1 = 1; m_v0 = !red; m_pc = red ? t : m_pc + 32'd4;
            end
        end else begin
            if (!stall) begin m_v1 = 0; m_v0 = 0; end
            if (red) begin m_pend = 1; m_pendTgt = t; end
        end
        @(posedge clk);
        #1;
        chk("addr",     a1, m_pc);
        chk("instr",    i1, m_instr);
        chk("instrPc",  p1, m_instrPc);
        chk("valid",    {31'd0, v1}, {31'd0, m_v1});
        chk("pending",  {31'd0, rp1}, {31'd0, m_pend});
        chk("addr0",    a0, m_pc);
        chk("instrPc0", p0, m_instrPc);
        chk("valid0",   {31'd0, v0}, {31'd0, m_v0});
        chk("pending0", {31'd0, rp0}, {31'd0, m_pend});
        imemData = $urandom;
    endtask

    task automatic idle_inputs();
        stall = 0; takeBranch = 0; jumpEnable = 0; jrEnable = 0;
        braPc = 0; braImm = 0; jumpTarget = 0; jrTarget = 0;
    endtask

    initial begin
        rst = 1; imemReady = 1; imemData = $urandom;
        idle_inputs();
        m_pc = 0; m_instr = 0; m_instrPc = 0; m_pendTgt = 0;
        m_v1 = 0; m_v0 = 0; m_pend = 0;
        @(negedge clk);

        // reset state
        cycle();
        chk("rst_addr", a1, 32'h3000);
        chk("rst_valid", {31'd0, v1}, 32'd0);
        chk("rst_instrPc", p1, 32'd0);

        // sequential fetch
        rst = 0;
        cycle();
        chk("seq_addr1", a1, 32'h3004);
        chk("seq_pc1", p1, 32'h3000);
        chk("seq_v1", {31'd0, v1}, 32'd1);
        cycle();
        chk("seq_addr2", a1, 32'h3008);

        // backward branch at pc=0x3008
        takeBranch = 1; braPc = 32'h3004; braImm = 16'hFFFE;
        cycle();
        chk("bb_addr", a1, 32'h3000);
        chk("bb_pc", p1, 32'h3008);
        chk("bb_ds1", {31'd0, v1}, 32'd1);
        chk("bb_ds0", {31'd0, v0}, 32'd0);
        idle_inputs();
        cycle();
        cycle();
        chk("back_to_3008", a1, 32'h3008);

        // redirect during memory wait
        imemReady = 0; takeBranch = 1; braPc = 32'h3004; braImm = 16'h0010;
        cycle();
        chk("wait_pend", {31'd0, rp1}, 32'd1);
        chk("wait_addr", a1, 32'h3008);
        idle_inputs();
        imemReady = 1;
        cycle();
        chk("wait_pc", p1, 32'h3008);
        chk("wait_valid", {31'd0, v1}, 32'd1);
        chk("wait_tgt", a1, 32'h3048);
        chk("wait_pend0", {31'd0, rp1}, 32'd0);

        // two-cycle stall with a held branch
        stall = 1; takeBranch = 1; braPc = 32'h3044; braImm = 16'h0004;
        cycle();
        cycle();
        chk("stall_addr", a1, 32'h3048);
        chk("stall_pc", p1, 32'h3008);
        chk("stall_pend", {31'd0, rp1}, 32'd1);
        idle_inputs();
        cycle();
        chk("stall_ds", p1, 32'h3048);
        chk("stall_tgt", a1, 32'h3058);
        cycle();
        chk("stall_once_pc", p1, 32'h3058);
        chk("stall_once_addr", a1, 32'h305C);

        // priority: jump over branch, then jr over both
        takeBranch = 1; braPc = 32'h3004; braImm = 16'h0100;
        jumpEnable = 1; jumpTarget = 26'h100;
        cycle();
        chk("prio_j", a1, 32'h0000_0400);
        jrEnable = 1; jrTarget = 32'h1234_5678;
        cycle();
        chk("prio_jr", a1, 32'h1234_5678);

        // pc wrap
        jrTarget = 32'hFFFF_FFFC; jumpEnable = 0; takeBranch = 0;
        cycle();
        idle_inputs();
        cycle();
        chk("wrap", a1, 32'h0000_0000);

        // reset while pending
        imemReady = 0; takeBranch = 1; braPc = 32'h5000; braImm = 16'h0100;
        cycle();
        chk("rp_pend", {31'd0, rp1}, 32'd1);
        idle_inputs();
        rst = 1;
        cycle();
        chk("rp_addr", a1, 32'h3000);
        chk("rp_clr", {31'd0, rp1}, 32'd0);
        chk("rp_valid", {31'd0, v1}, 32'd0);
        rst = 0; imemReady = 1;
        cycle();
        chk("rp_noold", a1, 32'h3004);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 40) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            imemReady  = ($urandom_range(0, 3) != 0);
            takeBranch = ($urandom_range(0, 5) == 0);
            jumpEnable = ($urandom_range(0, 9) == 0);
            jrEnable   = ($urandom_range(0, 9) == 0);
            braPc      = $urandom;
            braImm     = 16'($urandom);
            jumpTarget = 26'($urandom);
            jrTarget   = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
